dcache_wt: RTL and testbench



---
 rtl/dcache_wt.sv | 159 +++++++++++++++
 tb/tb_dcache_wt.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Sits behind the MEM stage and in front of a req/ack data RAM.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STAT_EN.
module dcache_wt #(
  parameter int unsigned IDX_BITS  = 4,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ren,
  input  logic                 mem_wen,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [31:0]          mem_dout,
  output logic [31:0]          mem_din,
  output logic                 mem_stall,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  input  logic                 ram_ack
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_miss
`endif
);

  localparam int unsigned LINES    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = ADDR_BITS - IDX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                state;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic [IDX_BITS-1:0]   lat_idx;
  logic [TAG_BITS-1:0]   lat_tag;
  logic                  lat_hit;
  logic                  unused_byte_bits;

  // Lookup of the live pipeline address and of the address latched for the RAM
  assign req_idx = mem_addr[IDX_BITS+1:2];
  assign req_tag = mem_addr[ADDR_BITS-1:IDX_BITS+2];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign lat_idx = ram_addr[IDX_BITS+1:2];
  assign lat_tag = ram_addr[ADDR_BITS-1:IDX_BITS+2];
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  assign unused_byte_bits = ^mem_addr[1:0];

  // Pipeline-facing response: hit data and stall are combinational
  always_comb begin
    mem_din   = '0;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_wen) begin
          mem_stall = 1'b1;
        end else if (mem_ren) begin
          if (hit) mem_din = data_q[req_idx];
          else     mem_stall = 1'b1;
        end
      end
      S_RD: begin
        mem_stall = !ram_ack;
        if (ram_ack) mem_din = ram_rdata;
      end
      S_WR: begin
        mem_stall = !ram_ack;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  // Control FSM with registered RAM interface and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      valid_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_wen) begin
            state     <= S_WR;
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= {mem_addr[ADDR_BITS-1:2], 2'b00};
            ram_wdata <= mem_dout;
          end else if (mem_ren && !hit) begin
            state    <= S_RD;
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= {mem_addr[ADDR_BITS-1:2], 2'b00};
          end
        end
        S_RD: begin
          if (ram_ack) begin
            state            <= S_IDLE;
            ram_req          <= 1'b0;
            valid_q[lat_idx] <= 1'b1;
          end
        end
        S_WR: begin
          if (ram_ack) begin
            state   <= S_IDLE;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays: fill on read completion, update on a store that hits
  always_ff @(posedge clk) begin
    if (!rst && ram_ack) begin
      if (state == S_RD) begin
        tag_q[lat_idx]  <= lat_tag;
        data_q[lat_idx] <= ram_rdata;
      end else if (state == S_WR && lat_hit) begin
        data_q[lat_idx] <= ram_wdata;
      end
    end
  end

`ifdef DCACHE_STAT_EN
  // Completed read hits and read fills
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (state == S_IDLE && mem_ren && !mem_wen && hit) stat_hit <= stat_hit + 32'd1;
      if (state == S_RD && ram_ack)                      stat_miss <= stat_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: scoreboard of expected responses,
// a reference cache model and a req/ack RAM model with variable latency.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  always #5 clk = ~clk;

  dcache_wt #(.IDX_BITS(4), .ADDR_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
`ifdef DCACHE_STAT_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } exp_t;

  exp_t sb[$];

  // Reference cache state and expected RAM contents
  bit          ref_valid [16];
  logic [25:0] ref_tag   [16];
  logic [31:0] ref_data  [16];
  logic [31:0] exp_mem [logic [31:0]];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  // RAM model state
  logic [31:0] ram_mem [logic [31:0]];
  int          ram_lat    = 3;
  bit          ram_auto   = 1'b1;
  logic        force_ack  = 1'b0;
  logic [31:0] force_data = 32'h0;
  bit          busy;
  int          cnt;

  function automatic logic [31:0] mem_pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return mem_pattern(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return mem_pattern(a);
  endfunction

  // RAM responder: acks ram_lat cycles after it first sees ram_req
  initial begin
    ram_ack   = 1'b0;
    ram_rdata = 32'h0;
    busy      = 1'b0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      ram_ack = 1'b0;
      if (!ram_auto) begin
        busy      = 1'b0;
        ram_ack   = force_ack;
        ram_rdata = force_data;
      end else if (!ram_req) begin
        busy = 1'b0;
      end else if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
      end else begin
        cnt++;
        if (cnt == ram_lat) begin
          ram_ack = 1'b1;
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
          else        ram_rdata = ram_rd(ram_addr);
        end
      end
    end
  end

  // Simultaneous load and store is not a legal pipeline request
  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (!(mem_ren === 1'b1 && mem_wen === 1'b1))
        else $error("mem_ren and mem_wen asserted together");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Predict one access and push it on the scoreboard
  task automatic push_expect(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [3:0]  idx;
    logic [25:0] tg;
    bit          h;
    idx = a[5:2];
    tg  = a[31:6];
    h   = ref_valid[idx] && (ref_tag[idx] == tg);
    e.is_wr = wr;
    e.addr  = {a[31:2], 2'b00};
    if (wr) begin
      e.stall = 1 + ram_lat;
      e.data  = wd;
      exp_mem[e.addr] = wd;
      if (h) ref_data[idx] = wd;
    end else if (h) begin
      e.stall = 0;
      e.data  = ref_data[idx];
      exp_hits++;
    end else begin
      e.stall = 1 + ram_lat;
      e.data  = exp_rd(e.addr);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_data[idx]  = e.data;
      exp_misses++;
    end
    sb.push_back(e);
  endtask

  // Issue one load/store, watch it complete, compare with the scoreboard entry
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input string nm, output int o_stall, output logic [31:0] o_data);
    exp_t        e;
    bit          done;
    bit          saw;
    bit          unstable;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wd;
    push_expect(wr, a, wd);
    mem_ren  = !wr;
    mem_wen  = wr;
    mem_addr = a;
    mem_dout = wd;
    done = 1'b0; saw = 1'b0; unstable = 1'b0;
    cap_we = 1'b0; cap_addr = 32'h0; cap_wd = 32'h0;
    o_stall = 0;
    o_data  = 32'h0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (ram_req === 1'b1) begin
        if (!saw) begin
          saw = 1'b1; cap_we = ram_we; cap_addr = ram_addr; cap_wd = ram_wdata;
        end else if ({ram_we, ram_addr, ram_wdata} !== {cap_we, cap_addr, cap_wd}) begin
          unstable = 1'b1;
        end
      end
      if (mem_stall === 1'b0) begin
        done   = 1'b1;
        o_data = mem_din;
      end else begin
        o_stall++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: mem_stall still high after 64 cycles", nm);
    end
    checks++;
    if (o_stall !== e.stall) begin
      failures++;
      $display("FAIL %s_stall: got %0d cycles, expected %0d", nm, o_stall, e.stall);
    end
    checks++;
    if (saw !== (e.stall != 0)) begin
      failures++;
      $display("FAIL %s_ram_req: seen=%0d, expected %0d", nm, saw, (e.stall != 0));
    end
    if (saw) begin
      checks++;
      if (cap_we !== e.is_wr) begin
        failures++;
        $display("FAIL %s_ram_we: got %0b, expected %0b", nm, cap_we, e.is_wr);
      end
      checks++;
      if (cap_addr !== e.addr) begin
        failures++;
        $display("FAIL %s_ram_addr: got %08h, expected %08h", nm, cap_addr, e.addr);
      end
      checks++;
      if (unstable !== 1'b0) begin
        failures++;
        $display("FAIL %s_ram_stable: RAM request fields changed while ram_req high", nm);
      end
      if (e.is_wr) begin
        checks++;
        if (cap_wd !== e.data) begin
          failures++;
          $display("FAIL %s_ram_wdata: got %08h, expected %08h", nm, cap_wd, e.data);
        end
      end
    end
    if (!e.is_wr) begin
      checks++;
      if (o_data !== e.data) begin
        failures++;
        $display("FAIL %s_mem_din: got %08h, expected %08h", nm, o_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ram_req, ram_we, mem_stall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: req/we/stall=%03b, expected 000", {ram_req, ram_we, mem_stall});
    end
    checks++;
    if (ram_addr !== 32'h0 || ram_wdata !== 32'h0 || mem_din !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%08h wdata=%08h din=%08h, expected all 0", ram_addr, ram_wdata, mem_din);
    end
`ifdef DCACHE_STAT_EN
    checks++;
    if (stat_hit !== 32'h0 || stat_miss !== 32'h0) begin
      failures++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, expected 0 0", stat_hit, stat_miss);
    end
`endif
  endtask

  task automatic test_cold_read();
    int          st;
    logic [31:0] d;
    ram_lat = 3;
    ram_mem[32'h40] = 32'hDEAD_BEEF;
    exp_mem[32'h40] = 32'hDEAD_BEEF;
    do_access(1'b0, 32'h40, 32'h0, "cold_read", st, d);
    checks++;
    if (st !== 4 || d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL cold_read_spec: stall=%0d din=%08h, expected 4 deadbeef", st, d);
    end
  endtask

  task automatic test_read_hit();
    int          st;
    logic [31:0] d;
    do_access(1'b0, 32'h40, 32'h0, "read_hit", st, d);
    checks++;
    if (st !== 0 || d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_hit_spec: stall=%0d din=%08h, expected 0 deadbeef", st, d);
    end
  endtask

  task automatic test_store_hit();
    int          st;
    logic [31:0] d;
    do_access(1'b1, 32'h40, 32'h1234_5678, "store_hit_wr", st, d);
    do_access(1'b0, 32'h40, 32'h0, "store_hit_rd", st, d);
    checks++;
    if (st !== 0 || d !== 32'h1234_5678) begin
      failures++;
      $display("FAIL store_hit_spec: stall=%0d din=%08h, expected 0 12345678", st, d);
    end
  endtask

  task automatic test_store_miss();
    int          st;
    logic [31:0] d;
    do_access(1'b1, 32'h80, 32'h5555_AAAA, "store_miss_wr", st, d);
    do_access(1'b0, 32'h80, 32'h0, "store_miss_rd", st, d);
    checks++;
    if (st !== 4 || d !== 32'h5555_AAAA) begin
      failures++;
      $display("FAIL store_miss_spec: stall=%0d din=%08h, expected 4 5555aaaa", st, d);
    end
  endtask

  task automatic test_conflict();
    int          st;
    logic [31:0] d;
    logic [31:0] seq [4];
    seq[0] = 32'h840; seq[1] = 32'h40; seq[2] = 32'h440; seq[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, seq[i], 32'h0, "conflict", st, d);
      checks++;
      if (st === 0) begin
        failures++;
        $display("FAIL conflict_miss: access %0d to %08h hit, expected miss", i, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    int          st;
    logic [31:0] d;
    ram_auto  = 1'b0;
    force_ack = 1'b0;
    mem_ren   = 1'b1;
    mem_addr  = 32'h100;
    @(posedge clk);
    #1;
    checks++;
    if (ram_req !== 1'b1 || mem_stall !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pending: req=%0b stall=%0b, expected 1 1", ram_req, mem_stall);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mem_ren    = 1'b0;
    force_ack  = 1'b1;
    force_data = 32'hBAD0_BAD0;
    #2;
    checks++;
    if (ram_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort: req=%0b stall=%0b, expected 0 0", ram_req, mem_stall);
    end
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    ram_auto  = 1'b1;
    ref_reset();
`ifdef DCACHE_STAT_EN
    checks++;
    if (stat_miss !== 32'h0) begin
      failures++;
      $display("FAIL midrst_stat_miss: got %0d, expected 0", stat_miss);
    end
`endif
    ram_lat = 3;
    do_access(1'b0, 32'h100, 32'h0, "midrst_reread", st, d);
    checks++;
    if (st !== 4 || d === 32'hBAD0_BAD0) begin
      failures++;
      $display("FAIL midrst_nofill: stall=%0d din=%08h, expected miss with RAM data", st, d);
    end
  endtask

  task automatic test_back_to_back();
    int          st;
    logic [31:0] d;
    logic [31:0] a;
    bit          wr;
    for (int i = 0; i < 24; i++) begin
      ram_lat = int'($urandom_range(1, 4));
      a  = 32'(($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 2));
      wr = ($urandom_range(0, 2) == 0);
      do_access(wr, a, $urandom, "b2b", st, d);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_miss();
    test_back_to_back();
`ifdef DCACHE_STAT_EN
    checks++;
    if (stat_hit !== 32'(exp_hits) || stat_miss !== 32'(exp_misses)) begin
      failures++;
      $display("FAIL stats: hit=%0d miss=%0d, expected %0d %0d", stat_hit, stat_miss, exp_hits, exp_misses);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
